// File: rtl/shift_pkg.sv
// shift_pkg: direction mode encodings and frame-counter width helper shared by the shift register
package shift_pkg;
  localparam int MODE_MSB = 0;
  localparam int MODE_LSB = 1;
  localparam int MODE_RUN = 2;
  function automatic int cw_f(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulo-N counter with sync reset, sync clear and enable; wrap flags the N-1 -> 0 step
module mod_counter
  import shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = cw_f(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] value,
  output logic          wrap
);
  logic [CW-1:0] value_q, value_d;
  always_comb begin
    wrap    = en && !clr && value_q == CW'(N - 1);
    value_d = (clr || wrap) ? '0 : en ? value_q + CW'(1) : value_q;
  end
  always_ff @(posedge clock) value_q <= reset ? '0 : value_d;
  assign value = value_q;
endmodule

// File: rtl/shift_register_cnt.sv
// shift_register_cnt: serial shift register with parallel load, selectable direction and frame-done pulse
module shift_register_cnt
  import shift_pkg::*;
#(
  parameter int W    = 8,
  parameter int Mode = MODE_MSB,
  parameter int N    = W,
  localparam int CW  = cw_f(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in,
  input  logic          load,
  input  logic          pload,
  input  logic [W-1:0]  pdata,
  input  logic          dir,
  output logic [W-1:0]  out,
  output logic          sout,
  output logic [CW-1:0] count,
  output logic          done
);
  if (Mode < MODE_MSB || Mode > MODE_RUN) begin : g_bad_mode
    $error("shift_register_cnt: Mode must be 0, 1 or 2");
  end
  if (W < 1) begin : g_bad_w
    $error("shift_register_cnt: W must be >= 1");
  end
  if (N < 1) begin : g_bad_n
    $error("shift_register_cnt: N must be >= 1");
  end
  logic [W-1:0] out_q, out_d;
  logic done_q, done_d, lsb_dir, wrap;
  // shifts built from whole-vector shifts so W == 1 degenerates to out <- in
  always_comb begin
    lsb_dir = (Mode == MODE_RUN) ? dir : (Mode == MODE_LSB);
    out_d   = pload ? pdata : !load ? out_q :
              lsb_dir ? (out_q >> 1) | (W'(in) << (W - 1)) : (out_q << 1) | W'(in);
    done_d  = wrap;
  end
  always_ff @(posedge clock) begin
    out_q  <= reset ? '0 : out_d;
    done_q <= reset ? 1'b0 : done_d;
  end
  mod_counter #(.N(N), .CW(CW)) u_cnt (
    .clock(clock),
    .reset(reset),
    .clr  (pload),
    .en   (load && !pload),
    .value(count),
    .wrap (wrap)
  );
  assign out  = out_q;
  assign done = done_q;
  assign sout = !reset && (lsb_dir ? out_q[0] : out_q[W-1]);
endmodule
